// File: rtl/arashi_merge_cache_if.sv
// Handshake bundle for the merge cache: per-thread write side and the single consumer side.
// master drives writes and out_ready; slave is the merge cache itself.
interface arashi_merge_cache_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2
);
  localparam int THREAD_NUM = 1 << THREAD_NUM_WIDTH;

  logic [THREAD_NUM-1:0]            w_ena;
  logic [DATA_WIDTH*THREAD_NUM-1:0] data_in;
  logic [THREAD_NUM-1:0]            w_ready;
  logic [DATA_WIDTH-1:0]            data_out;
  logic [THREAD_NUM_WIDTH-1:0]      thread_id_out;
  logic                             out_valid;
  logic                             out_ready;
  logic                             idle;

  modport master (
    output w_ena, data_in, out_ready,
    input  w_ready, data_out, thread_id_out, out_valid, idle
  );

  modport slave (
    input  w_ena, data_in, out_ready,
    output w_ready, data_out, thread_id_out, out_valid, idle
  );
endinterface

// File: rtl/arashi_merge_cache.sv
// Per-thread FIFOs merged by an RR/fixed-priority arbiter into one registered output stage.
// Latency: write edge + 1; out_ready low stalls the stage and FIFOs fill until w_ready drops.
module arashi_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic [AW:0]      count
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];
endmodule

module arashi_merge_cache #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int DEPTH_WIDTH      = 2,
  parameter int ARB_MODE         = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  arashi_merge_cache_if.slave  bus
);
  localparam int TN    = 1 << THREAD_NUM_WIDTH;
  localparam int DEPTH = 1 << DEPTH_WIDTH;

  typedef struct packed {
    logic [THREAD_NUM_WIDTH-1:0] tid;
    logic [DATA_WIDTH-1:0]       dat;
  } out_t;

  logic [DEPTH_WIDTH:0]        count [TN];
  logic [DATA_WIDTH-1:0]       head  [TN];
  logic [TN-1:0]               eligible;
  logic [TN-1:0]               w_rdy;
  logic [TN-1:0]               push;
  logic [TN-1:0]               pop;
  logic [THREAD_NUM_WIDTH-1:0] last;
  logic [THREAD_NUM_WIDTH-1:0] grant;
  logic [THREAD_NUM_WIDTH-1:0] idx;
  logic                        any_elig;
  logic                        adv;
  logic                        out_vld;
  out_t                        out_q;

  assign adv = !out_vld || bus.out_ready;

  for (genvar i = 0; i < TN; i++) begin : g_thread
    assign eligible[i] = (count[i] != '0);
    assign w_rdy[i]    = (count[i] != (DEPTH_WIDTH+1)'(DEPTH));
    assign push[i]     = bus.w_ena[i] && w_rdy[i];
    assign pop[i]      = adv && any_elig && (grant == THREAD_NUM_WIDTH'(i));

    arashi_fifo #(.WIDTH(DATA_WIDTH), .AW(DEPTH_WIDTH)) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .flush  (flush),
      .push   (push[i]),
      .pop    (pop[i]),
      .wr_dat (bus.data_in[DATA_WIDTH*i +: DATA_WIDTH]),
      .rd_dat (head[i]),
      .count  (count[i])
    );
  end

  // RR scans upward from last+1 and wraps; the final candidate is last itself.
  always_comb begin
    grant    = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int k = 0; k < TN; k++) begin
      idx = (ARB_MODE == 1) ? THREAD_NUM_WIDTH'(k) : last + THREAD_NUM_WIDTH'(k + 1);
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        grant    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld <= 1'b0;
      out_q   <= '0;
      last    <= THREAD_NUM_WIDTH'(TN - 1);
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (adv) begin
      if (any_elig) begin
        out_vld   <= 1'b1;
        out_q.dat <= head[grant];
        out_q.tid <= grant;
        last      <= grant;
      end else begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.w_ready       = w_rdy;
  assign bus.out_valid     = out_vld;
  assign bus.data_out      = out_q.dat;
  assign bus.thread_id_out = out_q.tid;
  assign bus.idle          = !(|eligible) && !out_vld;
endmodule

// File: tb/tb_arashi_merge_cache.sv
// Drives one round-robin and one fixed-priority instance with identical stimulus and
// compares both against a queue-based reference model plus directed expectations.
module tb_arashi_merge_cache;
  localparam int DW    = 8;
  localparam int TNW   = 2;
  localparam int TN    = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              flush = 1'b0;
  logic [TN-1:0]     w_ena = '0;
  logic [DW*TN-1:0]  data_in = '0;
  logic              out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arashi_merge_cache_if #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TNW)) bus_rr ();
  arashi_merge_cache_if #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TNW)) bus_fp ();

  assign bus_rr.w_ena     = w_ena;
  assign bus_rr.data_in   = data_in;
  assign bus_rr.out_ready = out_ready;
  assign bus_fp.w_ena     = w_ena;
  assign bus_fp.data_in   = data_in;
  assign bus_fp.out_ready = out_ready;

  arashi_merge_cache #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TNW), .DEPTH_WIDTH(2), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus_rr));
  arashi_merge_cache #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TNW), .DEPTH_WIDTH(2), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus_fp));

  // Reference model, index 0 = round-robin, 1 = fixed priority.
  logic [DW-1:0] mq [2][TN][$];
  logic          m_ov   [2];
  logic [DW-1:0] m_od   [2];
  int            m_ot   [2];
  int            m_last [2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < TN; i++) mq[m][i].delete();
      m_ov[m]   = 1'b0;
      m_od[m]   = '0;
      m_ot[m]   = 0;
      m_last[m] = TN - 1;
    end
  endfunction

  function automatic void model_edge();
    int g;
    int t;
    bit [TN-1:0] can_push;
    if (!rstn) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (flush) begin
        for (int i = 0; i < TN; i++) mq[m][i].delete();
        m_ov[m] = 1'b0;
      end else begin
        for (int i = 0; i < TN; i++) can_push[i] = (mq[m][i].size() < DEPTH);
        if (!m_ov[m] || out_ready) begin
          g = -1;
          for (int k = 0; k < TN; k++) begin
            t = (m == 1) ? k : (m_last[m] + 1 + k) % TN;
            if (g < 0 && mq[m][t].size() > 0) g = t;
          end
          if (g >= 0) begin
            m_od[m]   = mq[m][g].pop_front();
            m_ot[m]   = g;
            m_ov[m]   = 1'b1;
            m_last[m] = g;
          end else begin
            m_ov[m] = 1'b0;
          end
        end
        for (int i = 0; i < TN; i++)
          if (w_ena[i] && can_push[i]) mq[m][i].push_back(data_in[DW*i +: DW]);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic          ov;
    logic          idl;
    logic [DW-1:0] od;
    logic [TNW-1:0] ot;
    logic [TN-1:0] wr;
    logic [TN-1:0] exp_wr;
    bit            all_empty;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) begin
        ov = bus_rr.out_valid; od = bus_rr.data_out; ot = bus_rr.thread_id_out;
        wr = bus_rr.w_ready;   idl = bus_rr.idle;
      end else begin
        ov = bus_fp.out_valid; od = bus_fp.data_out; ot = bus_fp.thread_id_out;
        wr = bus_fp.w_ready;   idl = bus_fp.idle;
      end
      all_empty = 1'b1;
      for (int i = 0; i < TN; i++) begin
        exp_wr[i] = (mq[m][i].size() < DEPTH);
        if (mq[m][i].size() != 0) all_empty = 1'b0;
      end
      chk($sformatf("%s/m%0d/out_valid", tag, m), 32'(ov), 32'(m_ov[m]));
      chk($sformatf("%s/m%0d/data_out", tag, m), 32'(od), 32'(m_od[m]));
      chk($sformatf("%s/m%0d/thread_id", tag, m), 32'(ot), 32'(m_ot[m]));
      chk($sformatf("%s/m%0d/w_ready", tag, m), 32'(wr), 32'(exp_wr));
      chk($sformatf("%s/m%0d/idle", tag, m), 32'(idl), 32'(all_empty && !m_ov[m]));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset state
    model_reset();
    #2;
    check_all("reset");
    chk("reset/w_ready", 32'(bus_rr.w_ready), 32'hF);
    chk("reset/idle", 32'(bus_rr.idle), 32'h1);
    rstn = 1'b1;
    step("idle");

    // Minimum latency on a single thread
    out_ready = 1'b1;
    w_ena = 4'b0100;
    data_in = 32'h00A5_0000;
    step("lat_e0");
    chk("lat_e0/valid", 32'(bus_rr.out_valid), 32'h0);
    w_ena = '0;
    step("lat_e1");
    chk("lat_e1/valid", 32'(bus_rr.out_valid), 32'h1);
    chk("lat_e1/data", 32'(bus_rr.data_out), 32'hA5);
    chk("lat_e1/tid", 32'(bus_rr.thread_id_out), 32'h2);
    step("lat_e2");
    chk("lat_e2/valid", 32'(bus_rr.out_valid), 32'h0);

    // Arbitration order with two words per thread
    do_reset("rst_arb");
    out_ready = 1'b1;
    w_ena = 4'hF;
    data_in = 32'h1312_1110;
    step("pre0");
    data_in = 32'h2322_2120;
    step("pre1");
    w_ena = '0;
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("rr_seq%0d/tid", n), 32'(bus_rr.thread_id_out), 32'(n % 4));
      chk($sformatf("rr_seq%0d/data", n), 32'(bus_rr.data_out), 32'((n < 4 ? 8'h10 : 8'h20) + n % 4));
      chk($sformatf("fp_seq%0d/tid", n), 32'(bus_fp.thread_id_out), 32'(n / 2));
      chk($sformatf("fp_seq%0d/data", n), 32'(bus_fp.data_out), 32'((n % 2 == 1 ? 8'h20 : 8'h10) + n / 2));
      step($sformatf("arb%0d", n));
    end
    chk("arb_end/valid", 32'(bus_rr.out_valid), 32'h0);

    // Full FIFO under backpressure
    do_reset("rst_full");
    out_ready = 1'b0;
    w_ena = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      data_in = 32'(8'h30 + k) << 8;
      step($sformatf("full_w%0d", k));
      if (k == 3) chk("full_w3/w_ready1", 32'(bus_rr.w_ready[1]), 32'h1);
      if (k == 4) chk("full_w4/w_ready1", 32'(bus_rr.w_ready[1]), 32'h0);
    end
    w_ena = '0;
    step("stall0");
    step("stall1");
    chk("stall/data", 32'(bus_rr.data_out), 32'h30);
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("drain%0d/valid", n), 32'(bus_rr.out_valid), 32'h1);
      chk($sformatf("drain%0d/data", n), 32'(bus_rr.data_out), 32'(8'h30 + n));
      step($sformatf("drain%0d", n));
    end
    chk("drain_end/valid", 32'(bus_rr.out_valid), 32'h0);

    // Flush with every FIFO occupied and the output stage valid
    do_reset("rst_flush");
    out_ready = 1'b0;
    w_ena = 4'hF;
    data_in = $urandom;
    step("fl_pre0");
    data_in = $urandom;
    step("fl_pre1");
    chk("fl_pre/valid", 32'(bus_rr.out_valid), 32'h1);
    flush = 1'b1;
    data_in = $urandom;
    step("flush");
    chk("flush/valid", 32'(bus_rr.out_valid), 32'h0);
    chk("flush/idle", 32'(bus_fp.idle), 32'h1);
    chk("flush/w_ready", 32'(bus_fp.w_ready), 32'hF);
    flush = 1'b0;
    w_ena = '0;
    out_ready = 1'b1;
    step("post_flush");
    chk("post_flush/idle", 32'(bus_rr.idle), 32'h1);

    // Asynchronous reset with data queued
    out_ready = 1'b0;
    w_ena = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      data_in = 32'(8'h50 + k) << 24;
      step($sformatf("mid_w%0d", k));
    end
    w_ena = '0;
    do_reset("mid_rst");
    chk("mid_rst/valid", 32'(bus_rr.out_valid), 32'h0);
    chk("mid_rst/w_ready", 32'(bus_rr.w_ready), 32'hF);
    chk("mid_rst/idle", 32'(bus_rr.idle), 32'h1);
    out_ready = 1'b1;
    step("mid_post0");
    step("mid_post1");
    chk("mid_post/valid", 32'(bus_fp.out_valid), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      w_ena     = TN'($urandom);
      data_in   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 249) == 0) do_reset("rand_rst");
      step("rand");
    end
    w_ena = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) step("rand_drain");
    chk("final/idle", 32'(bus_rr.idle), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
